lc4_iter_divider: RTL and testbench

- Multi-cycle, unsigned restoring divider acting as the responder for the execute stage's divide/modulo requests (DIV quotient, MOD remainder).
- Replaces the single-cycle combinational divide path. The execute stage issues a request with a start pulse and stalls on o_busy until o_valid.
- Sits beside the ALU in the X stage and obeys the pipeline's global write enable and flush.

---
 rtl/lc4_iter_divider_pkg.sv | 12 +
 rtl/lc4_div_step.sv | 28 ++
 rtl/lc4_iter_divider.sv | 117 +++++++++++
 tb/tb_lc4_iter_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lc4_iter_divider_pkg.sv
// Shared definitions for the LC4 iterative divider: state encoding and default width.
package lc4_iter_divider_pkg;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  localparam int unsigned DivWidthDefault = 16;

endpackage

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step on a {rem, quo} register pair.
module lc4_div_step
  import lc4_iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidthDefault
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int unsigned RemW = WIDTH + 1;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] div_ext;
  logic             fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    div_ext  = {2'b00, divisor};
    fits     = (shifted >= div_ext);
    rem_next = fits ? RemW'(shifted - div_ext) : shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/lc4_iter_divider.sv
// Multi-cycle unsigned restoring divider for the X stage (DIV quotient / MOD remainder).
module lc4_iter_divider
  import lc4_iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH           = DivWidthDefault,
  parameter int unsigned ITERS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gwe,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned Steps = WIDTH / ITERS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  div_state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   rem_chain [ITERS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain [ITERS_PER_CYCLE+1];

  logic accept;
  logic last_iter;
  logic div_zero;

  assign accept    = gwe && i_start && !i_flush && (state_q != DivBusy);
  assign last_iter = (state_q == DivBusy) && (cnt_q == CntW'(1));
  assign div_zero  = (div_q == '0);

  // Chain of restoring steps evaluated within a single clock.
  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;

  for (genvar g = 0; g < ITERS_PER_CYCLE; g++) begin : g_step
    lc4_div_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .rem      (rem_chain[g]),
      .quo      (quo_chain[g]),
      .divisor  (div_q),
      .rem_next (rem_chain[g+1]),
      .quo_next (quo_chain[g+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DivIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (gwe) begin
      if (i_flush) begin
        state_d = DivIdle;
      end else begin
        unique case (state_q)
          DivIdle: if (i_start) state_d = DivBusy;
          DivBusy: if (cnt_q == CntW'(1)) state_d = DivDone;
          DivDone: state_d = i_start ? DivBusy : DivIdle;
          default: state_d = DivIdle;
        endcase
      end
    end
  end

  always_comb begin
    o_busy  = (state_q == DivBusy);
    o_valid = (state_q == DivDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (accept) begin
      cnt_q <= CntW'(Steps);
      rem_q <= '0;
      quo_q <= i_dividend;
      div_q <= i_divisor;
    end else if (gwe && !i_flush && (state_q == DivBusy)) begin
      cnt_q <= cnt_q - CntW'(1);
      rem_q <= rem_chain[ITERS_PER_CYCLE];
      quo_q <= quo_chain[ITERS_PER_CYCLE];
      if (last_iter) begin
        // LC4 defines x/0 and x%0 as zero; the raw datapath would give all-ones / dividend.
        quotient_q  <= div_zero ? '0 : quo_chain[ITERS_PER_CYCLE];
        remainder_q <= div_zero ? '0 : rem_chain[ITERS_PER_CYCLE][WIDTH-1:0];
      end
    end
  end

  assign o_quotient  = quotient_q;
  assign o_remainder = remainder_q;

endmodule

// File: tb/tb_lc4_iter_divider.sv
// Directed and random checks of lc4_iter_divider against a plain-arithmetic reference.
module tb_lc4_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gwe;
  logic        i_start;
  logic        i_flush;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int total = 0;
  int bad   = 0;
  int lat;
  int busy_seen;
  logic [15:0] exp_q, exp_r;

  lc4_iter_divider #(
    .WIDTH           (16),
    .ITERS_PER_CYCLE (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gwe         (gwe),
    .i_start     (i_start),
    .i_flush     (i_flush),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_quo(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : a / b;
  endfunction

  function automatic logic [15:0] ref_rem(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'd0 : a % b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (o_busy) busy_seen++;
      tick();
      lat++;
    end
  endtask

  task automatic start_req(input logic [15:0] a, input logic [15:0] b);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    lat        = 1;
    busy_seen  = 0;
    exp_q      = ref_quo(a, b);
    exp_r      = ref_rem(a, b);
  endtask

  // Waits for o_valid; optionally issues a new request during the DONE cycle.
  task automatic wait_done(input int exp_lat, input int exp_busy, input string tag,
                           input bit chain, input logic [15:0] a2, input logic [15:0] b2);
    while (!o_valid && lat < 300) step_cycles(1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_cycles"}, busy_seen, exp_busy);
    chk({tag, " quotient"}, o_quotient, exp_q);
    chk({tag, " remainder"}, o_remainder, exp_r);
    if (chain) begin
      start_req(a2, b2);
      chk({tag, " chained_busy"}, o_busy, 1'b1);
    end else begin
      tick();
    end
    chk({tag, " valid_one_cycle"}, o_valid, 1'b0);
  endtask

  initial begin
    int valid_seen;
    logic [15:0] prev_q, prev_r;
    logic [15:0] ra, rb;

    rst_n      = 1'b0;
    gwe        = 1'b1;
    i_start    = 1'b0;
    i_flush    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    #12;
    chk("reset busy", o_busy, 1'b0);
    chk("reset valid", o_valid, 1'b0);
    chk("reset quotient", o_quotient, 16'd0);
    chk("reset remainder", o_remainder, 16'd0);
    rst_n = 1'b1;
    tick();

    start_req(16'd100, 16'd7);
    wait_done(17, 16, "basic_100_7", 1'b0, '0, '0);

    start_req(16'hFFFF, 16'h0001);
    wait_done(17, 16, "ffff_1", 1'b0, '0, '0);
    start_req(16'h0005, 16'h0009);
    wait_done(17, 16, "5_9", 1'b0, '0, '0);
    start_req(16'h8000, 16'h8000);
    wait_done(17, 16, "8000_8000", 1'b0, '0, '0);
    start_req(16'h1234, 16'h0000);
    wait_done(17, 16, "div_zero", 1'b0, '0, '0);

    // Start pulse during BUSY must not re-capture operands.
    start_req(16'd50, 16'd3);
    step_cycles(3);
    i_dividend = 16'd9;
    i_divisor  = 16'd2;
    i_start    = 1'b1;
    step_cycles(1);
    i_start    = 1'b0;
    wait_done(17, 16, "ignored_start", 1'b1, 16'd9, 16'd2);
    wait_done(17, 16, "back_to_back", 1'b0, '0, '0);

    // Flush at iteration 8: no valid, outputs hold.
    prev_q = exp_q;
    prev_r = exp_r;
    start_req(16'd77, 16'd5);
    step_cycles(7);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush busy_drop", o_busy, 1'b0);
    valid_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (o_valid) valid_seen++;
      tick();
    end
    chk("flush no_valid", valid_seen, 0);
    chk("flush hold_quotient", o_quotient, prev_q);
    chk("flush hold_remainder", o_remainder, prev_r);

    // Flush beats simultaneous start.
    i_dividend = 16'd10;
    i_divisor  = 16'd3;
    i_start    = 1'b1;
    i_flush    = 1'b1;
    tick();
    i_start    = 1'b0;
    i_flush    = 1'b0;
    chk("flush_priority busy", o_busy, 1'b0);

    // gwe low for 5 cycles stretches latency by exactly 5.
    start_req(16'd77, 16'd5);
    step_cycles(5);
    gwe = 1'b0;
    step_cycles(5);
    gwe = 1'b1;
    wait_done(22, 21, "gwe_stall", 1'b0, '0, '0);

    // Asynchronous reset mid-BUSY, between clock edges.
    start_req(16'd200, 16'd9);
    step_cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset busy", o_busy, 1'b0);
    chk("async_reset valid", o_valid, 1'b0);
    chk("async_reset quotient", o_quotient, 16'd0);
    chk("async_reset remainder", o_remainder, 16'd0);
    rst_n = 1'b1;
    tick();
    start_req(16'd100, 16'd7);
    wait_done(17, 16, "after_reset", 1'b0, '0, '0);

    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      start_req(ra, rb);
      wait_done(17, 16, "random", 1'b0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
